// File: rtl/pdp_rdma_eg_rsp_unpack.sv
`default_nettype none
// ============================================================================
// Module   : pdp_rdma_eg_rsp_unpack
// Brief    : Splits 514-bit PDP RDMA read-response words (512 data bits plus
//            a 2-bit half mask) into 256-bit beats for the PDP datapath.
//            It returns one latency-FIFO credit per consumed word and counts
//            atoms against a per-surface total.
// Revision : 1.0  initial release
// ============================================================================
module pdp_rdma_eg_rsp_unpack #(
    parameter int CNT_W = 14
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rst,
    input  logic             rsp_valid_in,
    output logic             rsp_ready_in,
    input  logic [513:0]     rsp_pd_in,
    output logic             dp_valid,
    input  logic             dp_ready,
    output logic [255:0]     dp_data,
    output logic             dp_last,
    output logic             rsp_pop,
    input  logic [CNT_W-1:0] cfg_atom_total,
    output logic [CNT_W-1:0] atom_cnt,
    output logic             done,
    output logic             mask_err
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LO    = 2'd1,
        ST_HI    = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_hi_pend;
    logic [511:0]       r_hold;
    logic               r_pop_pend;

    logic [1:0]         w_mask;
    logic               w_accept;
    logic               w_hs;
    logic               w_last_hs;
    logic               w_drop;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_wrap;

    assign w_mask    = rsp_pd_in[513:512];
    assign w_hs      = dp_valid & dp_ready;
    assign w_last_hs = w_hs & dp_last;

    // A new word may enter when the holder is empty or its final beat leaves
    // this cycle; the reset gate keeps the port closed while reset is held.
    assign rsp_ready_in = ~nvdla_core_rst & ((r_state == ST_EMPTY) | w_last_hs);
    assign w_accept     = rsp_valid_in & rsp_ready_in;
    assign w_drop       = w_accept & (w_mask == 2'b00);

    // Beat presentation comes purely from registered state, so rsp_valid_in
    // has no combinational route to dp_valid.
    assign dp_valid = (r_state != ST_EMPTY);
    assign dp_last  = (r_state == ST_HI) | ((r_state == ST_LO) & ~r_hi_pend);
    assign dp_data  = (r_state == ST_HI) ? r_hold[511:256] :
                      (r_state == ST_LO) ? r_hold[255:0]   : 256'd0;

    assign w_cnt_inc = atom_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    assign w_wrap    = (cfg_atom_total != '0) && (w_cnt_inc == cfg_atom_total);

    // Holding-register state machine: load on a non-empty accept, otherwise
    // advance LO->HI or drain to EMPTY on a beat handshake.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            r_state   <= ST_EMPTY;
            r_hi_pend <= 1'b0;
        end else if (w_accept && (w_mask != 2'b00)) begin
            r_hold <= rsp_pd_in[511:0];
            case (w_mask)
                2'b01: begin
                    r_state   <= ST_LO;
                    r_hi_pend <= 1'b0;
                end
                2'b10: begin
                    r_state   <= ST_HI;
                    r_hi_pend <= 1'b0;
                end
                default: begin
                    r_state   <= ST_LO;
                    r_hi_pend <= 1'b1;
                end
            endcase
        end else if (w_hs) begin
            if ((r_state == ST_LO) && r_hi_pend) begin
                r_state   <= ST_HI;
                r_hi_pend <= 1'b0;
            end else begin
                r_state   <= ST_EMPTY;
                r_hi_pend <= 1'b0;
            end
        end
    end

    // Credit return: a last handshake and a dropped word in the same cycle
    // need two pops, so the second is parked in a one-bit pending flag.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            rsp_pop    <= 1'b0;
            r_pop_pend <= 1'b0;
            mask_err   <= 1'b0;
        end else begin
            rsp_pop    <= w_last_hs | w_drop | r_pop_pend;
            r_pop_pend <= (w_last_hs & w_drop) | (r_pop_pend & (w_last_hs | w_drop));
            if (w_drop) begin
                mask_err <= 1'b1;
            end
        end
    end

    // Atom counter: wraps to zero with a done pulse at the surface total,
    // free-runs when the total is zero.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            atom_cnt <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (w_hs) begin
                if (w_wrap) begin
                    atom_cnt <= '0;
                    done     <= 1'b1;
                end else begin
                    atom_cnt <= w_cnt_inc;
                end
            end
        end
    end

endmodule
`default_nettype wire
